approx_mask_ctrl: RTL and testbench

- Upstream control stage for the masked one-bit approximate adder cells: owns the per-bit mask vector that selects exact (mask=1) or approximate OR-sum (mask=0) operation in each bit slice of a WIDTH-bit adder.
- Accepts a requested accuracy level over a valid/ready handshake.
- Ramps the mask toward the requested level one bit per cycle, so adder switching activity changes gradually and the consuming datapath never sees multi-bit mask jumps.

---
 rtl/approx_mask_ctrl_pkg.sv | 25 ++
 rtl/approx_mask_ctrl_level_to_mask.sv | 17 +
 rtl/approx_mask_ctrl.sv | 117 +++++++++++
 tb/tb_approx_mask_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/approx_mask_ctrl_pkg.sv
// Shared definitions for the approximate-adder mask controller: defaults,
// FSM state type and the level-to-thermometer helper.
package approx_mask_ctrl_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned LVL_W_DEF = 5;
  localparam int unsigned MAX_W     = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_e;

  // Thermometer of lvl ones packed against bit width-1; callers truncate to width.
  function automatic logic [MAX_W-1:0] level_to_thermo(input int unsigned lvl,
                                                       input int unsigned width);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      r[i] = (i < width) && ((i + lvl) >= width);
    end
    return r;
  endfunction

endpackage

// File: rtl/approx_mask_ctrl_level_to_mask.sv
// Combinational thermometer decoder: level exact slices counted from the MSB.
module approx_mask_ctrl_level_to_mask
  import approx_mask_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned LVL_W = LVL_W_DEF
) (
  input  logic [LVL_W-1:0] level,
  output logic [WIDTH-1:0] thermo_c
);

  logic [MAX_W-1:0] thermo_full;

  assign thermo_full = level_to_thermo(32'(level), WIDTH);
  assign thermo_c    = thermo_full[WIDTH-1:0];

endmodule

// File: rtl/approx_mask_ctrl.sv
// Accuracy-level controller: accepts a target level and ramps the exact-slice
// mask toward it one bit per cycle, with hold and a settled pulse.
module approx_mask_ctrl
  import approx_mask_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned LVL_W = LVL_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [LVL_W-1:0] req_level,
  input  logic             hold,
  output logic [WIDTH-1:0] mask,
  output logic [LVL_W-1:0] level_cur,
  output logic             busy,
  output logic             settled
);

  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(WIDTH);
  localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);

  state_e           state_q,   state_d;
  logic [LVL_W-1:0] level_q,   level_d;
  logic [LVL_W-1:0] target_q,  target_d;
  logic             ready_q,   ready_d;
  logic             busy_q,    busy_d;
  logic             settled_q, settled_d;
  logic [WIDTH-1:0] mask_q,    mask_d;
  logic [LVL_W-1:0] req_clamped;

  assign req_clamped = (req_level > LVL_MAX) ? LVL_MAX : req_level;

  // Mask is decoded from the next level so the register always matches level_cur.
  approx_mask_ctrl_level_to_mask #(
    .WIDTH (WIDTH),
    .LVL_W (LVL_W)
  ) u_level_to_mask (
    .level    (level_d),
    .thermo_c (mask_d)
  );

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    target_d  = target_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    settled_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (req_valid && ready_q) begin
          target_d = req_clamped;
          if (req_clamped == level_q) begin
            settled_d = 1'b1;
          end else begin
            state_d = ST_RAMP;
            ready_d = 1'b0;
            busy_d  = 1'b1;
          end
        end
      end

      ST_RAMP: begin
        ready_d = 1'b0;
        busy_d  = 1'b1;
        if (!hold) begin
          level_d = (target_q > level_q) ? (level_q + LVL_ONE) : (level_q - LVL_ONE);
          if (level_d == target_q) begin
            state_d   = ST_IDLE;
            ready_d   = 1'b1;
            busy_d    = 1'b0;
            settled_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Reset lands on the fully exact configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      level_q   <= LVL_MAX;
      target_q  <= LVL_MAX;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      settled_q <= 1'b0;
      mask_q    <= '1;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      target_q  <= target_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      settled_q <= settled_d;
      mask_q    <= mask_d;
    end
  end

  assign req_ready = ready_q;
  assign mask      = mask_q;
  assign level_cur = level_q;
  assign busy      = busy_q;
  assign settled   = settled_q;

endmodule

// File: tb/tb_approx_mask_ctrl.sv
// Bench for approx_mask_ctrl: directed scenarios plus random traffic, all
// compared every cycle against a level/target reference model.
module tb_approx_mask_ctrl;

  localparam int W  = 16;
  localparam int LW = 5;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [LW-1:0] req_level;
  logic          hold;
  logic [W-1:0]  mask;
  logic [LW-1:0] level_cur;
  logic          busy;
  logic          settled;

  int n_vec;
  int n_bad;

  // Reference model state: current level, target, ramping flag, settled pulse.
  int m_lvl;
  int m_tgt;
  bit m_ramp;
  bit m_settled;

  logic [W-1:0] prev_mask;
  bit           prev_ok;

  approx_mask_ctrl #(.WIDTH(W), .LVL_W(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_level (req_level),
    .hold      (hold),
    .mask      (mask),
    .level_cur (level_cur),
    .busy      (busy),
    .settled   (settled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_mask(input int lvl);
    logic [31:0] t;
    t = 32'h0000_FFFF << (W - lvl);
    return t[W-1:0];
  endfunction

  task automatic model_reset();
    m_lvl     = W;
    m_tgt     = W;
    m_ramp    = 1'b0;
    m_settled = 1'b0;
    prev_ok   = 1'b0;
  endtask

  task automatic model_edge(input bit v, input int lvl, input bit h);
    m_settled = 1'b0;
    if (!m_ramp) begin
      if (v) begin
        m_tgt = (lvl > W) ? W : lvl;
        if (m_tgt == m_lvl) m_settled = 1'b1;
        else                m_ramp    = 1'b1;
      end
    end else if (!h) begin
      m_lvl = (m_tgt > m_lvl) ? m_lvl + 1 : m_lvl - 1;
      if (m_lvl == m_tgt) begin
        m_ramp    = 1'b0;
        m_settled = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    logic [W-1:0] inv;
    chk("mask",      32'(mask),      32'(exp_mask(m_lvl)));
    chk("level_cur", 32'(level_cur), 32'(m_lvl));
    chk("req_ready", 32'(req_ready), 32'(!m_ramp));
    chk("busy",      32'(busy),      32'(m_ramp));
    chk("settled",   32'(settled),   32'(m_settled));
    chk("popcount",  32'($countones(mask)), 32'(level_cur));
    inv = ~mask;
    chk("thermo",    32'((inv & (inv + W'(1))) == '0), 32'd1);
    if (prev_ok) chk("hamming", 32'($countones(mask ^ prev_mask) <= 1), 32'd1);
    prev_mask = mask;
    prev_ok   = 1'b1;
  endtask

  // One clock: drive, take the edge, advance the model, check just after.
  task automatic cyc(input bit v, input int lvl, input bit h);
    req_valid = v;
    req_level = LW'(lvl);
    hold      = h;
    @(posedge clk);
    model_edge(v, lvl, h);
    #1;
    check_outputs();
  endtask

  // Asynchronous reset, checked before any clock edge, released at the next negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_mask",    32'(mask),      32'h0000_FFFF);
    chk("rst_level",   32'(level_cur), 32'd16);
    chk("rst_ready",   32'(req_ready), 32'd1);
    chk("rst_busy",    32'(busy),      32'd0);
    chk("rst_settled", 32'(settled),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_level = '0;
    hold      = 1'b0;
    prev_mask = '1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Ramp down 16 -> 12.
    cyc(1, 12, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0);
    chk("ramp12_mask",    32'(mask),    32'h0000_FFF0);
    chk("ramp12_settled", 32'(settled), 32'd1);

    // Ramp up 12 -> 14 with a 3-cycle hold after the first step.
    cyc(1, 14, 0);
    cyc(0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("hold_mask",    32'(mask),    32'h0000_FFFC);
    chk("hold_settled", 32'(settled), 32'd1);

    // Back to 16, then an out-of-range request clamps to a no-op.
    cyc(1, 16, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(1, 31, 0);
    chk("clamp_settled", 32'(settled), 32'd1);
    chk("clamp_busy",    32'(busy),    32'd0);
    chk("clamp_mask",    32'(mask),    32'h0000_FFFF);

    // Full ramp to 0 with a pending request held on the bus.
    cyc(1, 0, 0);
    for (int i = 0; i < 16; i++) cyc(1, 8, 0);
    chk("bp_zero_mask", 32'(mask),    32'h0000_0000);
    chk("bp_settled",   32'(settled), 32'd1);
    cyc(1, 8, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0);
    chk("bp_ff00_mask", 32'(mask), 32'h0000_FF00);

    // Reset in the middle of a 16 -> 4 ramp.
    do_reset();
    cyc(1, 4, 0);
    for (int i = 0; i < 40 && m_lvl != 9; i++) cyc(0, 0, 0);
    chk("midramp_reached9", 32'(level_cur), 32'd9);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_mask",  32'(mask),      32'h0000_FFFF);
    chk("midrst_level", 32'(level_cur), 32'd16);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0);
    chk("midrst_nosettle", 32'(settled), 32'd0);
    cyc(1, 15, 0);
    cyc(0, 0, 0);
    chk("post_rst_mask",    32'(mask),    32'h0000_FFFE);
    chk("post_rst_settled", 32'(settled), 32'd1);

    // Random traffic with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 2) == 0, int'($urandom_range(0, 31)), $urandom_range(0, 3) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
